// File: rtl/jk_flipflop.sv
// jk_flipflop: bank of WIDTH independent positive-edge JK flip-flops with
// shared clock, synchronous active-high reset and clock enable.
// Optional per-bit toggle counters are built when JK_TOGGLE_CNT_EN is defined;
// without it the o_toggle_cnt port is absent and the JK core is unchanged.
module jk_flipflop #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CNT_WIDTH   = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_en,
    input  logic [WIDTH-1:0]           i_j,
    input  logic [WIDTH-1:0]           i_k,
    output logic [WIDTH-1:0]           o_q,
`ifdef JK_TOGGLE_CNT_EN
    output logic [WIDTH*CNT_WIDTH-1:0] o_toggle_cnt,
`endif
    output logic [WIDTH-1:0]           o_qn
);

    // Parameter sanity, evaluated at elaboration only
    if (WIDTH < 1) begin : g_bad_width
        $error("jk_flipflop: WIDTH must be >= 1");
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("jk_flipflop: CNT_WIDTH must be >= 1");
    end

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next-state: J sets a low bit, ~K keeps a high bit; J=K=1 therefore toggles
    always_comb begin
        q_d = q_q;
        if (i_en) begin
            q_d = (i_j & ~q_q) | (~i_k & q_q);
        end
    end

    // State register; reset overrides enable and any pending toggle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign o_q  = q_q;
    // Derived from the same flop so o_q and o_qn can never agree
    assign o_qn = ~q_q;

`ifdef JK_TOGGLE_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q [WIDTH];
    logic [CNT_WIDTH-1:0] cnt_d [WIDTH];

    // Count only real value changes; q_d equals q_q whenever i_en is low,
    // so hold and set/reset-to-same-value never increment
    always_comb begin
        for (int n = 0; n < WIDTH; n++) begin
            cnt_d[n] = cnt_q[n];
            if (q_d[n] != q_q[n]) begin
                cnt_d[n] = cnt_q[n] + CNT_WIDTH'(1);
            end
        end
    end

    // Counter registers, cleared together with the state
    always_ff @(posedge i_clk) begin
        for (int n = 0; n < WIDTH; n++) begin
            if (i_rst) begin
                cnt_q[n] <= '0;
            end else begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    // Pack counters, bit n in [n*CNT_WIDTH +: CNT_WIDTH]
    always_comb begin
        o_toggle_cnt = '0;
        for (int n = 0; n < WIDTH; n++) begin
            o_toggle_cnt[n*CNT_WIDTH +: CNT_WIDTH] = cnt_q[n];
        end
    end
`endif

endmodule

// File: tb/tb_jk_flipflop.sv
// Bench for jk_flipflop: a 1-bit and a 4-bit (RESET_VALUE=1010) instance
// compared against a behavioural JK model. Counter checks compile in only
// when JK_TOGGLE_CNT_EN is defined.
module tb_jk_flipflop;

    localparam int CW = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       j1  = 1'b0, k1 = 1'b0;
    logic [3:0] j4  = '0,   k4 = '0;
    logic       u1_q, u1_qn;
    logic [3:0] u4_q, u4_qn;
`ifdef JK_TOGGLE_CNT_EN
    logic [CW-1:0]   u1_cnt;
    logic [4*CW-1:0] u4_cnt;
`endif

    int total = 0;
    int pass  = 0;

    // model state
    logic       m1_q;
    logic [3:0] m4_q;
    int         m1_cnt;
    int         m4_cnt [4];

    always #5 clk = ~clk;

    jk_flipflop #(.WIDTH(1), .RESET_VALUE(1'b0), .CNT_WIDTH(CW)) u1 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_j(j1), .i_k(k1),
        .o_q(u1_q),
`ifdef JK_TOGGLE_CNT_EN
        .o_toggle_cnt(u1_cnt),
`endif
        .o_qn(u1_qn)
    );

    jk_flipflop #(.WIDTH(4), .RESET_VALUE(4'b1010), .CNT_WIDTH(CW)) u4 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_j(j4), .i_k(k4),
        .o_q(u4_q),
`ifdef JK_TOGGLE_CNT_EN
        .o_toggle_cnt(u4_cnt),
`endif
        .o_qn(u4_qn)
    );

    // JK truth table
    function automatic logic jk_next(logic q, logic j, logic k);
        if (j && k) return ~q;
        if (j)      return 1'b1;
        if (k)      return 1'b0;
        return q;
    endfunction

    // One rising edge: compute model next state from the inputs set at the
    // previous falling edge, then sample the DUT 1 time unit after the edge
    task automatic step();
        logic       n1;
        logic [3:0] n4;
        if (rst) begin
            n1 = 1'b0;
            n4 = 4'b1010;
        end else if (!en) begin
            n1 = m1_q;
            n4 = m4_q;
        end else begin
            n1 = jk_next(m1_q, j1, k1);
            for (int b = 0; b < 4; b++) n4[b] = jk_next(m4_q[b], j4[b], k4[b]);
        end
        if (rst) begin
            m1_cnt = 0;
            for (int b = 0; b < 4; b++) m4_cnt[b] = 0;
        end else begin
            if (n1 !== m1_q) m1_cnt = (m1_cnt + 1) % (1 << CW);
            for (int b = 0; b < 4; b++)
                if (n4[b] !== m4_q[b]) m4_cnt[b] = (m4_cnt[b] + 1) % (1 << CW);
        end
        @(posedge clk);
        m1_q = n1;
        m4_q = n4;
        #1;
    endtask

    task automatic to_negedge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        to_negedge();
        rst = 1'b1; en = 1'b1; j1 = 1'b1; k1 = 1'b1; j4 = 4'hF; k4 = 4'hF;
        step();
        total++;
        if (u1_q !== 1'b0) $display("FAIL reset_q: got %b expected 0", u1_q);
        else pass++;
        total++;
        if (u1_qn !== 1'b1) $display("FAIL reset_qn: got %b expected 1", u1_qn);
        else pass++;
        total++;
        if (u4_q !== 4'b1010) $display("FAIL reset_q4: got %b expected 1010", u4_q);
        else pass++;
`ifdef JK_TOGGLE_CNT_EN
        total++;
        if (u1_cnt !== '0) $display("FAIL reset_cnt: got %0d expected 0", u1_cnt);
        else pass++;
`endif
        to_negedge();
        rst = 1'b0;
    endtask

    task automatic test_function_table();
        logic [1:0] jk_seq [6] = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b11, 2'b11};
        logic       exp_q  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            to_negedge();
            {j1, k1} = jk_seq[i];
            step();
            total++;
            if (u1_q !== exp_q[i] || u1_q !== m1_q)
                $display("FAIL func_table[%0d] jk=%b: got %b expected %b", i, jk_seq[i], u1_q, exp_q[i]);
            else pass++;
        end
    endtask

    task automatic test_enable();
        // q is 1 from the function table
        to_negedge();
        en = 1'b0; j1 = 1'b0; k1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (u1_q !== 1'b1) $display("FAIL enable_hold[%0d]: got %b expected 1", i, u1_q);
            else pass++;
        end
        to_negedge();
        en = 1'b1;
        step();
        total++;
        if (u1_q !== 1'b0) $display("FAIL enable_release: got %b expected 0", u1_q);
        else pass++;
    endtask

    task automatic test_sequence();
        to_negedge();
        rst = 1'b1;
        step();
        to_negedge();
        rst = 1'b0; en = 1'b1; j1 = 1'b0; k1 = 1'b0;
        #2;
        total++;
        if (u1_q !== 1'b0) $display("FAIL seq_low0: got %b expected 0", u1_q);
        else pass++;
        j1 = 1'b1; k1 = 1'b1;
        step();
        total++;
        if (u1_q !== 1'b1 || u1_qn !== 1'b0) $display("FAIL seq_edge1: got q=%b qn=%b expected q=1 qn=0", u1_q, u1_qn);
        else pass++;
        to_negedge();
        j1 = 1'b0; k1 = 1'b1;
        #2;
        total++;
        if (u1_q !== 1'b1) $display("FAIL seq_low1: got %b expected 1", u1_q);
        else pass++;
        step();
        total++;
        if (u1_q !== 1'b0 || u1_qn !== 1'b1) $display("FAIL seq_edge2: got q=%b qn=%b expected q=0 qn=1", u1_q, u1_qn);
        else pass++;
    endtask

    task automatic test_multibit();
        to_negedge();
        rst = 1'b1;
        step();
        total++;
        if (u4_q !== 4'b1010) $display("FAIL multi_reset: got %b expected 1010", u4_q);
        else pass++;
        to_negedge();
        rst = 1'b0; en = 1'b1; j4 = 4'b0011; k4 = 4'b0101;
        step();
        // hold b3=1, reset b2=0, set b1=1, toggle b0 0->1
        total++;
        if (u4_q !== 4'b1011 || u4_q !== m4_q) $display("FAIL multi_mix: got %b expected 1011", u4_q);
        else pass++;
        total++;
        if (u4_qn !== ~u4_q || u4_qn !== 4'b0100) $display("FAIL multi_qn: got %b expected 0100", u4_qn);
        else pass++;
    endtask

`ifdef JK_TOGGLE_CNT_EN
    task automatic test_toggle_cnt();
        int exp_cnt [5] = '{1, 2, 3, 0, 1};
        to_negedge();
        rst = 1'b1;
        step();
        to_negedge();
        rst = 1'b0; en = 1'b1; j1 = 1'b1; k1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (u1_cnt !== CW'(exp_cnt[i])) $display("FAIL cnt_toggle[%0d]: got %0d expected %0d", i, u1_cnt, exp_cnt[i]);
            else pass++;
        end
        to_negedge();
        k1 = 1'b0;
        step();
        total++;
        if (u1_cnt !== CW'(1) || u1_q !== 1'b1) $display("FAIL cnt_set_same: got cnt=%0d q=%b expected cnt=1 q=1", u1_cnt, u1_q);
        else pass++;
        to_negedge();
        rst = 1'b1;
        step();
        total++;
        if (u1_cnt !== '0) $display("FAIL cnt_reset: got %0d expected 0", u1_cnt);
        else pass++;
        to_negedge();
        rst = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            to_negedge();
            rst = ($urandom_range(0, 19) == 0);
            en  = ($urandom_range(0, 3) != 0);
            j1  = 1'($urandom);
            k1  = 1'($urandom);
            j4  = 4'($urandom);
            k4  = 4'($urandom);
            step();
            total++;
            if (u1_q !== m1_q || u1_qn !== ~m1_q)
                $display("FAIL rand1[%0d]: got q=%b qn=%b expected q=%b", i, u1_q, u1_qn, m1_q);
            else pass++;
            total++;
            if (u4_q !== m4_q || u4_qn !== ~m4_q)
                $display("FAIL rand4[%0d]: got q=%b qn=%b expected q=%b", i, u4_q, u4_qn, m4_q);
            else pass++;
`ifdef JK_TOGGLE_CNT_EN
            begin
                logic [4*CW-1:0] exp4;
                for (int b = 0; b < 4; b++) exp4[b*CW +: CW] = CW'(m4_cnt[b]);
                total++;
                if (u1_cnt !== CW'(m1_cnt) || u4_cnt !== exp4)
                    $display("FAIL rand_cnt[%0d]: got %h/%h expected %h/%h", i, u1_cnt, u4_cnt, CW'(m1_cnt), exp4);
                else pass++;
            end
`endif
        end
        to_negedge();
        rst = 1'b0;
    endtask

    initial begin
        m1_q   = 1'bx;
        m4_q   = 4'bx;
        m1_cnt = 0;
        for (int b = 0; b < 4; b++) m4_cnt[b] = 0;
        test_reset();
        test_function_table();
        test_enable();
        test_sequence();
        test_multibit();
`ifdef JK_TOGGLE_CNT_EN
        test_toggle_cnt();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
